// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus cycle engine: state encoding,
// idle bus levels and the RTC register map.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_GAP1 = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP2 = 3'd4
  } state_e;

  // Everything the engine drives toward the pad ring, kept together so the
  // idle/reset value is defined in exactly one place.
  typedef struct packed {
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_sel;
    logic       oe;
    logic [7:0] ad;
  } bus_out_t;

  localparam bus_out_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                    ad_sel: 1'b1, oe: 1'b0, ad: 8'h00};

  localparam logic [7:0] STATUS0      = 8'h00;
  localparam logic [7:0] STATUS1      = 8'h01;
  localparam logic [7:0] STATUS2      = 8'h02;
  localparam logic [7:0] DIG_TRIM     = 8'h10;
  localparam logic [7:0] SEC          = 8'h21;
  localparam logic [7:0] MIN          = 8'h22;
  localparam logic [7:0] HOUR         = 8'h23;
  localparam logic [7:0] DATE         = 8'h24;
  localparam logic [7:0] MONTH        = 8'h25;
  localparam logic [7:0] YEAR         = 8'h26;
  localparam logic [7:0] TMR_SEC      = 8'h41;
  localparam logic [7:0] TMR_MIN      = 8'h42;
  localparam logic [7:0] TMR_HOUR     = 8'h43;
  localparam logic [7:0] CMD_TRANSFER = 8'hF1;
  localparam logic [7:0] CMD_TIMER    = 8'hF2;

  // The counter runs down to zero inclusive, so an N-cycle phase loads N-1.
  function automatic logic [7:0] phase_load(input int unsigned cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter; done_o is high while the count sits at zero.
module rtc_phase_timer (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       done_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/rtc_bus_cycle_engine.sv
// Turns one accepted register request into a timed address-phase / data-phase
// cycle on the RTC multiplexed AD bus, returning read data on a 1-cycle pulse.
module rtc_bus_cycle_engine
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_PHASE = 7,
  parameter int unsigned T_GAP   = 7
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic [7:0] bus_ad_o,
  output logic       bus_ad_oe,
  input  logic [7:0] bus_ad_i,
  output logic       AD_o,
  output logic       RD,
  output logic       WR,
  output logic       CS
);

  localparam logic [7:0] LD_PHASE = phase_load(T_PHASE);
  localparam logic [7:0] LD_GAP   = phase_load(T_GAP);

  state_e     state_q;
  bus_out_t   bus_q;
  logic       busy_q, ready_q, rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       wr_q;
  logic [7:0] addr_q, data_q;

  logic       tmr_load, tmr_done;
  logic [7:0] tmr_val;
  logic       accept;

  assign accept = (state_q == ST_IDLE) && req_valid && ready_q;

  // Reload the shared timer on the same edge that enters the next phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = LD_PHASE;
    case (state_q)
      ST_IDLE: tmr_load = accept;
      ST_ADDR: begin tmr_load = tmr_done; tmr_val = LD_GAP;   end
      ST_GAP1: begin tmr_load = tmr_done; tmr_val = LD_PHASE; end
      ST_DATA: begin tmr_load = tmr_done; tmr_val = LD_GAP;   end
      default: tmr_load = 1'b0;
    endcase
  end

  rtc_phase_timer u_timer (
    .clk_i      (clk_i),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bus_q       <= BUS_IDLE;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      wr_q        <= 1'b0;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            data_q  <= req_data;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= ST_ADDR;
            bus_q   <= '{cs_n: 1'b0, rd_n: 1'b1, wr_n: 1'b0, ad_sel: 1'b0,
                         oe: 1'b1, ad: req_addr};
          end
        end
        ST_ADDR: begin
          if (tmr_done) begin
            state_q    <= ST_GAP1;
            bus_q.cs_n <= 1'b1;
            bus_q.wr_n <= 1'b1;
          end
        end
        ST_GAP1: begin
          // Address stays on the pads through GAP1 as hold time.
          if (tmr_done) begin
            state_q <= ST_DATA;
            bus_q   <= '{cs_n: 1'b0, rd_n: wr_q, wr_n: ~wr_q, ad_sel: 1'b1,
                         oe: wr_q, ad: (wr_q ? data_q : addr_q)};
          end
        end
        ST_DATA: begin
          if (tmr_done) begin
            state_q <= ST_GAP2;
            bus_q   <= '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, ad_sel: 1'b1,
                         oe: 1'b0, ad: bus_q.ad};
            if (!wr_q) begin
              rsp_data_q  <= bus_ad_i;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        ST_GAP2: begin
          if (tmr_done) begin
            state_q <= ST_IDLE;
            bus_q   <= BUS_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          bus_q   <= BUS_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign CS        = bus_q.cs_n;
  assign RD        = bus_q.rd_n;
  assign WR        = bus_q.wr_n;
  assign AD_o      = bus_q.ad_sel;
  assign bus_ad_oe = bus_q.oe;
  assign bus_ad_o  = bus_q.ad;

endmodule

// File: tb/tb_rtc_bus_cycle_engine.sv
// Self-checking bench: instance 0 uses default timing (7/7), instance 1 the
// minimum (1/1). Bus traces are checked cycle by cycle against a phase model.
module tb_rtc_bus_cycle_engine;
  import rtc_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2];
  logic       req_valid[2], req_wr[2];
  logic [7:0] req_addr[2], req_data[2], bus_in[2];
  logic       req_ready[2], rsp_valid[2], busy[2], oe[2], ad_o[2], rd_n[2], wr_n[2], cs_n[2];
  logic [7:0] rsp_data[2], bus_out[2];

  rtc_bus_cycle_engine #(.T_PHASE(7), .T_GAP(7)) dut0 (
    .clk_i(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wr(req_wr[0]), .req_addr(req_addr[0]), .req_data(req_data[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .busy(busy[0]),
    .bus_ad_o(bus_out[0]), .bus_ad_oe(oe[0]), .bus_ad_i(bus_in[0]),
    .AD_o(ad_o[0]), .RD(rd_n[0]), .WR(wr_n[0]), .CS(cs_n[0]));

  rtc_bus_cycle_engine #(.T_PHASE(1), .T_GAP(1)) dut1 (
    .clk_i(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wr(req_wr[1]), .req_addr(req_addr[1]), .req_data(req_data[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .busy(busy[1]),
    .bus_ad_o(bus_out[1]), .bus_ad_oe(oe[1]), .bus_ad_i(bus_in[1]),
    .AD_o(ad_o[1]), .RD(rd_n[1]), .WR(wr_n[1]), .CS(cs_n[1]));

  typedef struct packed {
    logic cs, rd, wr, ad, oe, busy, ready, rv;
  } ctl_t;

  int chk_cnt = 0;
  int pass_cnt = 0;

  ctl_t       obs_ctl[64];
  logic [7:0] obs_bus[64];
  logic [7:0] obs_rsp[64];
  int         obs_len;

  logic [7:0] addr_tbl[15];

  function automatic int tp_of(input int i);
    return (i == 0) ? 7 : 1;
  endfunction

  // Expected control levels k cycles after acceptance (k=0 is the first ADDR
  // cycle); derived from phase boundaries only.
  function automatic ctl_t model(input int k, input logic w, input int tp, input int tg);
    ctl_t e;
    e = '{cs: 1'b1, rd: 1'b1, wr: 1'b1, ad: 1'b1, oe: 1'b0, busy: 1'b1, ready: 1'b0, rv: 1'b0};
    if (k < tp) begin
      e.cs = 1'b0; e.wr = 1'b0; e.ad = 1'b0; e.oe = 1'b1;
    end else if (k < tp + tg) begin
      e.ad = 1'b0; e.oe = 1'b1;
    end else if (k < 2 * tp + tg) begin
      e.cs = 1'b0;
      if (w) begin e.wr = 1'b0; e.oe = 1'b1; end
      else   begin e.rd = 1'b0; end
    end else if (k < 2 * (tp + tg)) begin
      e.rv = !w && (k == 2 * tp + tg);
    end else begin
      e.busy = 1'b0; e.ready = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [7:0] exp_bus(input int k, input int tp, input int tg,
                                          input logic [7:0] a, input logic [7:0] d);
    return (k < tp + tg) ? a : d;
  endfunction

  function automatic ctl_t observe(input int i);
    return '{cs: cs_n[i], rd: rd_n[i], wr: wr_n[i], ad: ad_o[i], oe: oe[i],
             busy: busy[i], ready: req_ready[i], rv: rsp_valid[i]};
  endfunction

  // Issues one request and records the bus trace from the first ADDR cycle up to
  // and including the first IDLE cycle (or until abort_k).
  task automatic run_txn(input int i, input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] rdval, input logic hold,
                         input logic [7:0] na, input logic [7:0] nd,
                         input int abort_k, output logic acc_ok);
    int n, tp, tg, total;
    tp = tp_of(i); tg = tp; total = 2 * (tp + tg);
    n = 0;
    while (req_ready[i] !== 1'b1 && n < 64) begin
      @(negedge clk); n++;
    end
    acc_ok = (req_ready[i] === 1'b1);
    req_valid[i] = 1'b1; req_wr[i] = w; req_addr[i] = a; req_data[i] = d;
    @(negedge clk);
    if (hold) begin
      req_addr[i] = na; req_data[i] = nd;
    end else begin
      req_valid[i] = 1'b0;
      req_wr[i] = 1'($urandom); req_addr[i] = 8'($urandom); req_data[i] = 8'($urandom);
    end
    obs_len = total;
    for (int k = 0; k <= total; k++) begin
      bus_in[i] = (k >= tp + tg && k < 2 * tp + tg) ? rdval : 8'($urandom);
      obs_ctl[k] = observe(i); obs_bus[k] = bus_out[i]; obs_rsp[k] = rsp_data[i];
      if (k == abort_k) begin
        obs_len = k;
        return;
      end
      if (k < total) @(negedge clk);
    end
    $display("txn inst=%0d %s addr=%h data=%h rd_in=%h", i, w ? "WRITE" : "READ", a, d, rdval);
  endtask

  task automatic test_reset();
    ctl_t e;
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e = model(1000, 1'b0, 1, 1);
      chk_cnt++;
      if (observe(i) !== e || bus_out[i] !== 8'h00 || rsp_data[i] !== 8'h00)
        $display("FAIL reset_state inst=%0d got ctl=%b bus=%h rsp=%h exp ctl=%b bus=00 rsp=00",
                 i, observe(i), bus_out[i], rsp_data[i], e);
      else pass_cnt++;
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_defaults();
    logic ok; ctl_t e;
    run_txn(0, 1'b1, STATUS2, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00, -1, ok);
    chk_cnt++;
    if (!ok) $display("FAIL wr_def_accept got ready=0 exp ready=1"); else pass_cnt++;
    for (int k = 0; k <= obs_len; k++) begin
      e = model(k, 1'b1, 7, 7); chk_cnt++;
      if (obs_ctl[k] !== e || (e.oe && obs_bus[k] !== exp_bus(k, 7, 7, STATUS2, 8'h10)))
        $display("FAIL wr_defaults k=%0d got ctl=%b bus=%h exp ctl=%b bus=%h",
                 k, obs_ctl[k], obs_bus[k], e, exp_bus(k, 7, 7, STATUS2, 8'h10));
      else pass_cnt++;
    end
  endtask

  task automatic test_read();
    logic ok; ctl_t e;
    run_txn(0, 1'b0, SEC, 8'hA5, 8'h45, 1'b0, 8'h00, 8'h00, -1, ok);
    chk_cnt++;
    if (!ok) $display("FAIL rd_accept got ready=0 exp ready=1"); else pass_cnt++;
    for (int k = 0; k <= obs_len; k++) begin
      e = model(k, 1'b0, 7, 7); chk_cnt++;
      if (obs_ctl[k] !== e || (e.oe && obs_bus[k] !== SEC) || (e.rv && obs_rsp[k] !== 8'h45))
        $display("FAIL rd_sec k=%0d got ctl=%b bus=%h rsp=%h exp ctl=%b bus=%h rsp=45",
                 k, obs_ctl[k], obs_bus[k], obs_rsp[k], e, SEC);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic ok, w; ctl_t e; logic [7:0] a, d, rv; int bad;
    for (int t = 0; t < 6; t++) begin
      w = 1'($urandom); a = addr_tbl[$urandom_range(0, 14)];
      d = 8'($urandom); rv = 8'($urandom);
      run_txn(t % 2, w, a, d, rv, 1'b0, 8'h00, 8'h00, -1, ok);
      bad = ok ? 0 : 1;
      for (int k = 0; k <= obs_len; k++) begin
        e = model(k, w, tp_of(t % 2), tp_of(t % 2));
        if (obs_ctl[k] !== e || (e.oe && obs_bus[k] !== exp_bus(k, tp_of(t % 2), tp_of(t % 2), a, d))
            || (e.rv && obs_rsp[k] !== rv)) bad++;
      end
      chk_cnt++;
      if (bad != 0)
        $display("FAIL random t=%0d inst=%0d w=%0d addr=%h got %0d bad cycles exp 0", t, t % 2, w, a, bad);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic ok; ctl_t e; int idle_bad;
    logic [7:0] qa[3], qd[3];
    qa[0] = HOUR; qd[0] = 8'h03; qa[1] = DATE; qd[1] = 8'h26; qa[2] = MONTH; qd[2] = 8'h04;
    for (int t = 0; t < 3; t++) begin
      run_txn(0, 1'b1, qa[t], qd[t], 8'h00, (t < 2), qa[(t + 1) % 3], qd[(t + 1) % 3], -1, ok);
      chk_cnt++;
      if (!ok) $display("FAIL b2b_accept t=%0d got ready=0 exp ready=1", t); else pass_cnt++;
      for (int k = 0; k <= obs_len; k++) begin
        e = model(k, 1'b1, 7, 7); chk_cnt++;
        if (obs_ctl[k] !== e || (e.oe && obs_bus[k] !== exp_bus(k, 7, 7, qa[t], qd[t])))
          $display("FAIL b2b t=%0d k=%0d got ctl=%b bus=%h exp ctl=%b bus=%h",
                   t, k, obs_ctl[k], obs_bus[k], e, exp_bus(k, 7, 7, qa[t], qd[t]));
        else pass_cnt++;
      end
    end
    idle_bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy[0] !== 1'b0 || cs_n[0] !== 1'b1) idle_bad++;
    end
    chk_cnt++;
    if (idle_bad != 0) $display("FAIL b2b_no_dup got %0d busy cycles exp 0", idle_bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic ok; ctl_t e; int bad;
    run_txn(0, 1'b0, SEC, 8'h00, 8'h77, 1'b0, 8'h00, 8'h00, 7 + 7 + 2, ok);
    chk_cnt++;
    if (obs_ctl[obs_len] !== model(obs_len, 1'b0, 7, 7))
      $display("FAIL rst_mid_pre got ctl=%b exp ctl=%b", obs_ctl[obs_len], model(obs_len, 1'b0, 7, 7));
    else pass_cnt++;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    e = model(1000, 1'b0, 7, 7); chk_cnt++;
    if (observe(0) !== e || bus_out[0] !== 8'h00)
      $display("FAIL rst_mid_idle got ctl=%b bus=%h exp ctl=%b bus=00", observe(0), bus_out[0], e);
    else pass_cnt++;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0 || rd_n[0] !== 1'b1) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL rst_mid_quiet got %0d active cycles exp 0", bad); else pass_cnt++;
    run_txn(0, 1'b1, MIN, 8'h59, 8'h00, 1'b0, 8'h00, 8'h00, -1, ok);
    bad = ok ? 0 : 1;
    for (int k = 0; k <= obs_len; k++) begin
      e = model(k, 1'b1, 7, 7);
      if (obs_ctl[k] !== e || (e.oe && obs_bus[k] !== exp_bus(k, 7, 7, MIN, 8'h59))) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL rst_mid_after_wr got %0d bad cycles exp 0", bad); else pass_cnt++;
  endtask

  task automatic test_min_timing();
    logic ok; ctl_t e;
    run_txn(1, 1'b1, CMD_TRANSFER, 8'h5A, 8'h00, 1'b0, 8'h00, 8'h00, -1, ok);
    chk_cnt++;
    if (!ok || obs_len != 4) $display("FAIL min_len got ok=%0d len=%0d exp ok=1 len=4", ok, obs_len);
    else pass_cnt++;
    for (int k = 0; k <= obs_len; k++) begin
      e = model(k, 1'b1, 1, 1); chk_cnt++;
      if (obs_ctl[k] !== e || (e.oe && obs_bus[k] !== exp_bus(k, 1, 1, CMD_TRANSFER, 8'h5A)))
        $display("FAIL min_wr k=%0d got ctl=%b bus=%h exp ctl=%b bus=%h",
                 k, obs_ctl[k], obs_bus[k], e, exp_bus(k, 1, 1, CMD_TRANSFER, 8'h5A));
      else pass_cnt++;
    end
    run_txn(1, 1'b0, TMR_SEC, 8'h00, 8'h3C, 1'b0, 8'h00, 8'h00, -1, ok);
    for (int k = 0; k <= obs_len; k++) begin
      e = model(k, 1'b0, 1, 1); chk_cnt++;
      if (obs_ctl[k] !== e || (e.oe && obs_bus[k] !== TMR_SEC) || (e.rv && obs_rsp[k] !== 8'h3C))
        $display("FAIL min_rd k=%0d got ctl=%b bus=%h rsp=%h exp ctl=%b rsp=3c",
                 k, obs_ctl[k], obs_bus[k], obs_rsp[k], e);
      else pass_cnt++;
    end
  endtask

  initial begin
    addr_tbl = '{STATUS0, STATUS1, STATUS2, DIG_TRIM, SEC, MIN, HOUR, DATE, MONTH, YEAR,
                 TMR_SEC, TMR_MIN, TMR_HOUR, CMD_TRANSFER, CMD_TIMER};
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_wr[i] = 1'b0;
      req_addr[i] = 8'h00; req_data[i] = 8'h00; bus_in[i] = 8'h00;
    end
    test_reset();
    test_write_defaults();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_min_timing();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
